// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the RV32I core pipeline
package core_pkg;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    alu_ctrl_t  alu_ctrl;
    logic       alu_src;
    logic       valid;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use interlock and debug counters
module id_ex_pipe_reg
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_e_i,
  input  logic                  reg_write_d_i,
  input  logic [1:0]            result_src_d_i,
  input  logic                  mem_write_d_i,
  input  logic                  jump_d_i,
  input  logic                  branch_d_i,
  input  logic [3:0]            alu_ctrl_d_i,
  input  logic                  alu_src_d_i,
  input  logic [DATA_WIDTH-1:0] rd1_d_i,
  input  logic [DATA_WIDTH-1:0] rd2_d_i,
  input  logic [DATA_WIDTH-1:0] pc_d_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_d_i,
  input  logic [DATA_WIDTH-1:0] imm_ext_d_i,
  input  logic [ADDR_WIDTH-1:0] rs1_d_i,
  input  logic [ADDR_WIDTH-1:0] rs2_d_i,
  input  logic [ADDR_WIDTH-1:0] rd_d_i,
  input  logic                  valid_d_i,
  output logic                  reg_write_e_o,
  output logic [1:0]            result_src_e_o,
  output logic                  mem_write_e_o,
  output logic                  jump_e_o,
  output logic                  branch_e_o,
  output logic [3:0]            alu_ctrl_e_o,
  output logic                  alu_src_e_o,
  output logic [DATA_WIDTH-1:0] rd1_e_o,
  output logic [DATA_WIDTH-1:0] rd2_e_o,
  output logic [DATA_WIDTH-1:0] pc_e_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_e_o,
  output logic [DATA_WIDTH-1:0] imm_ext_e_o,
  output logic [ADDR_WIDTH-1:0] rs1_e_o,
  output logic [ADDR_WIDTH-1:0] rs2_e_o,
  output logic [ADDR_WIDTH-1:0] rd_e_o,
  output logic                  valid_e_o,
  output logic                  stall_d_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  id_ex_ctrl_t           ctrl_q;
  id_ex_ctrl_t           ctrl_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, pc_q, pc_plus4_q, imm_ext_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                  load_in_e;
  logic                  take_bubble;

  // An empty decode slot must never write state, even if its enables are stale.
  always_comb begin
    ctrl_d            = ID_EX_BUBBLE;
    ctrl_d.reg_write  = reg_write_d_i & valid_d_i;
    ctrl_d.result_src = result_src_d_i;
    ctrl_d.mem_write  = mem_write_d_i & valid_d_i;
    ctrl_d.jump       = jump_d_i & valid_d_i;
    ctrl_d.branch     = branch_d_i & valid_d_i;
    ctrl_d.alu_ctrl   = alu_ctrl_t'(alu_ctrl_d_i);
    ctrl_d.alu_src    = alu_src_d_i;
    ctrl_d.valid      = valid_d_i;
  end

  assign load_in_e = ctrl_q.valid & ctrl_q.reg_write &
                     (ctrl_q.result_src == RESULT_SRC_LOAD) & (rd_q != '0);
  assign stall_d_o = load_in_e & ((rd_q == rs1_d_i) | (rd_q == rs2_d_i));

  assign take_bubble = flush_e_i | stall_d_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= ID_EX_BUBBLE;
      rd1_q      <= '0;
      rd2_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      imm_ext_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else if (take_bubble) begin
      ctrl_q     <= ID_EX_BUBBLE;
      rd1_q      <= '0;
      rd2_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      imm_ext_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rd1_q      <= rd1_d_i;
      rd2_q      <= rd2_d_i;
      pc_q       <= pc_d_i;
      pc_plus4_q <= pc_plus4_d_i;
      imm_ext_q  <= imm_ext_d_i;
      rs1_q      <= rs1_d_i;
      rs2_q      <= rs2_d_i;
      rd_q       <= rd_d_i;
    end
  end

  assign reg_write_e_o  = ctrl_q.reg_write;
  assign result_src_e_o = ctrl_q.result_src;
  assign mem_write_e_o  = ctrl_q.mem_write;
  assign jump_e_o       = ctrl_q.jump;
  assign branch_e_o     = ctrl_q.branch;
  assign alu_ctrl_e_o   = ctrl_q.alu_ctrl;
  assign alu_src_e_o    = ctrl_q.alu_src;
  assign valid_e_o      = ctrl_q.valid;
  assign rd1_e_o        = rd1_q;
  assign rd2_e_o        = rd2_q;
  assign pc_e_o         = pc_q;
  assign pc_plus4_e_o   = pc_plus4_q;
  assign imm_ext_e_o    = imm_ext_q;
  assign rs1_e_o        = rs1_q;
  assign rs2_e_o        = rs2_q;
  assign rd_e_o         = rd_q;

  // A flush outranks the interlock, so a coincident stall is not counted.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (stall_d_o & ~flush_e_i),
    .count (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (flush_e_i),
    .count (flush_cnt_o)
  );

endmodule
